// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for the banked RAM arbiter.
// Included by the bank, the interface users and the top.
package banked_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        OREG,
        DONE
    } ram_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } ram_port_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/banked_ram_arb_if.sv
// picorv32-native request port: one instance per requester.
// The requester is the master, the RAM arbiter the slave.
interface banked_ram_arb_if;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/banked_ram_arb_bank.sv
// One RAM bank (ram_bank_be): WORDS x 32 with byte write enables.
// Address is registered on enable; read data follows the registered address.
module ram_bank_be
    import banked_ram_pkg::*;
#(
    parameter  int unsigned WORDS = 4096,
    localparam int unsigned AW    = clog2_u(WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] addr_q;

    // No reset: block RAM contents and address survive reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            addr_q <= addr_i;
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_q];

endmodule

// File: rtl/banked_ram_arb.sv
// Banked RAM shared by CPU (a) and DMA (b) ports via round-robin arbitration.
// Define BRAM_OUT_REG_EN to add a read output register (OREG state).
module banked_ram_arb
    import banked_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned BANK_WORDS = 4096
) (
    input  logic            clk,
    input  logic            resetn,
    banked_ram_arb_if.slave a,
    banked_ram_arb_if.slave b,
    output logic            a_busy,
    output logic            err
);

    localparam int unsigned RB    = clog2_u(BANK_WORDS);
    localparam int unsigned BB    = clog2_u(NUM_BANKS);
    localparam int unsigned BW    = (BB == 0) ? 1 : BB;
    localparam logic [31:0] TOTAL = 32'(NUM_BANKS * BANK_WORDS);

    ram_state_t    state_q, state_d;
    ram_port_t     grant_q, grant_d;
    ram_port_t     rr_q, rr_d;
    logic [RB-1:0] row_q, row_d;
    logic [BW-1:0] bank_q, bank_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          hit_q, hit_d;
    logic          err_q, err_d;

    logic          take;
    ram_port_t     pick;
    logic [31:0]   req_addr;
    logic [31:0]   off;
    logic [31:0]   idx;
    logic          hit;

    logic [NUM_BANKS-1:0] bank_en;
    logic [31:0]          bank_rd [NUM_BANKS];
    logic [31:0]          rd_mux;
    logic [31:0]          out_word;
    logic                 rd_ok;

    // Tie goes to rr_q, the port not granted last.
    always_comb begin
        take = a.valid | b.valid;
        unique case (1'b1)
            a.valid & b.valid:  pick = rr_q;
            a.valid & ~b.valid: pick = PORT_A;
            default:            pick = PORT_B;
        endcase
        req_addr = (pick == PORT_A) ? a.addr : b.addr;
        off      = req_addr - BASE_ADDR;
        idx      = off >> 2;
        hit      = (req_addr >= BASE_ADDR) && (idx < TOTAL);
    end

    always_comb begin
        grant_d = grant_q;
        rr_d    = rr_q;
        row_d   = row_q;
        bank_d  = bank_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        hit_d   = hit_q;
        err_d   = err_q;
        if (state_q == IDLE && take) begin
            grant_d = pick;
            rr_d    = (pick == PORT_A) ? PORT_B : PORT_A;
            row_d   = idx[RB-1:0];
            bank_d  = BW'(idx >> RB);
            wdata_d = (pick == PORT_A) ? a.wdata : b.wdata;
            wstrb_d = (pick == PORT_A) ? a.wstrb : b.wstrb;
            hit_d   = hit;
            err_d   = err_q | ~hit;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= PORT_A;
            rr_q    <= PORT_A;
            row_q   <= '0;
            bank_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            rr_q    <= rr_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (take) state_d = ISSUE;
            ISSUE: begin
`ifdef BRAM_OUT_REG_EN
                state_d = (wstrb_q == 4'h0) ? OREG : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef BRAM_OUT_REG_EN
            OREG: state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Only an in-range access enables a bank, so this also drops bad writes.
    always_comb begin
        bank_en = '0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_q == BW'(i)) begin
                bank_en[i] = (state_q == ISSUE) && hit_q;
                rd_mux     = bank_rd[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank_be #(
            .WORDS (BANK_WORDS)
        ) u_bank (
            .clk     (clk),
            .en_i    (bank_en[g]),
            .we_i    (wstrb_q),
            .addr_i  (row_q),
            .wdata_i (wdata_q),
            .rdata_o (bank_rd[g])
        );
    end

`ifdef BRAM_OUT_REG_EN
    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               rdata_q <= '0;
        else if (state_q == OREG)  rdata_q <= rd_mux;
    end

    assign out_word = rdata_q;
`else
    assign out_word = rd_mux;
`endif

    always_comb begin
        rd_ok   = (state_q == DONE) && hit_q && (wstrb_q == 4'h0);
        a.ready = (state_q == DONE) && (grant_q == PORT_A);
        b.ready = (state_q == DONE) && (grant_q == PORT_B);
        a.rdata = (rd_ok && grant_q == PORT_A) ? out_word : 32'h0;
        b.rdata = (rd_ok && grant_q == PORT_B) ? out_word : 32'h0;
        a_busy  = (state_q != IDLE) && (grant_q == PORT_B);
        err     = err_q;
    end

endmodule

// File: tb/tb_banked_ram_arb.sv
// Scoreboard bench for banked_ram_arb: directed accesses push expected
// responses; a negedge monitor pops and compares on every ready.
`timescale 1ns/1ps
module tb_banked_ram_arb;
    import banked_ram_pkg::*;

    typedef struct {
        ram_port_t   port;
        logic [31:0] data;
    } exp_t;

`ifdef BRAM_OUT_REG_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic a_busy;
    logic err;

    banked_ram_arb_if pa ();
    banked_ram_arb_if pb ();

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    banked_ram_arb dut (
        .clk    (clk),
        .resetn (resetn),
        .a      (pa),
        .b      (pb),
        .a_busy (a_busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void check_resp(ram_port_t p, logic [31:0] d);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: port %0d data %h, nothing pending", p, d);
            return;
        end
        e = q.pop_front();
        chk("resp_port", 32'(p), 32'(e.port));
        chk("resp_rdata", d, e.data);
    endfunction

    always @(negedge clk) begin
        if (pa.ready) check_resp(PORT_A, pa.rdata);
        else          chk("a_rdata_zero", pa.rdata, 32'h0);
        if (pb.ready) check_resp(PORT_B, pb.rdata);
        else          chk("b_rdata_zero", pb.rdata, 32'h0);
    end

    task automatic drive(ram_port_t p, logic v, logic [31:0] ad,
                         logic [31:0] wd, logic [3:0] st);
        if (p == PORT_A) begin
            pa.valid = v; pa.addr = ad; pa.wdata = wd; pa.wstrb = st;
        end else begin
            pb.valid = v; pb.addr = ad; pb.wdata = wd; pb.wstrb = st;
        end
    endtask

    task automatic expect_resp(ram_port_t p, logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic wait_ready(ram_port_t p, int exp_lat, string name);
        int  n;
        logic r;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            r = (p == PORT_A) ? pa.ready : pb.ready;
            if (r) break;
        end
        chk(name, 32'(n), 32'(exp_lat));
        if (p == PORT_A) pa.valid = 1'b0;
        else             pb.valid = 1'b0;
    endtask

    task automatic access(ram_port_t p, logic [31:0] ad, logic [31:0] wd,
                          logic [3:0] st, logic [31:0] exp, string name);
        @(posedge clk);
        #1;
        drive(p, 1'b1, ad, wd, st);
        expect_resp(p, exp);
        wait_ready(p, (st == 4'h0) ? RD_LAT : 2, name);
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_a_ready"}, 32'(pa.ready), 32'h0);
        chk({tag, "_b_ready"}, 32'(pb.ready), 32'h0);
        chk({tag, "_a_rdata"}, pa.rdata, 32'h0);
        chk({tag, "_b_rdata"}, pb.rdata, 32'h0);
        chk({tag, "_a_busy"}, 32'(a_busy), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        drive(PORT_A, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(PORT_B, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk) resetn = 1'b1;

        // Tie after reset: A first, B waits one transaction.
        @(posedge clk);
        #1;
        drive(PORT_A, 1'b1, 32'h0002_0020, 32'h1111_1111, 4'hF);
        drive(PORT_B, 1'b1, 32'h0002_0024, 32'h2222_2222, 4'hF);
        expect_resp(PORT_A, 32'h0);
        expect_resp(PORT_B, 32'h0);
        wait_ready(PORT_A, 2, "tie1_a_lat");
        chk("tie1_busy_a", 32'(a_busy), 32'h0);
        wait_ready(PORT_B, 3, "tie1_b_lat");
        chk("tie1_busy_b", 32'(a_busy), 32'h1);

        // A alone, then tie again: pointer now favours B.
        access(PORT_A, 32'h0002_0020, 32'h0, 4'h0, 32'h1111_1111, "a_rd20_lat");
        @(posedge clk);
        #1;
        drive(PORT_A, 1'b1, 32'h0002_0024, 32'h0, 4'h0);
        drive(PORT_B, 1'b1, 32'h0002_0020, 32'h0, 4'h0);
        expect_resp(PORT_B, 32'h1111_1111);
        expect_resp(PORT_A, 32'h2222_2222);
        wait_ready(PORT_B, RD_LAT, "tie2_b_lat");
        chk("tie2_busy_b", 32'(a_busy), 32'h1);
        wait_ready(PORT_A, RD_LAT + 1, "tie2_a_lat");
        chk("tie2_busy_a", 32'(a_busy), 32'h0);

        access(PORT_A, 32'h0002_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, "a_wr_lat");
        access(PORT_A, 32'h0002_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, "a_rd_lat");

        access(PORT_A, 32'h0002_0014, 32'hFFFF_FFFF, 4'hF, 32'h0, "strb_fill");
        access(PORT_A, 32'h0002_0014, 32'h1122_3344, 4'b0101, 32'h0, "strb_wr");
        access(PORT_B, 32'h0002_0014, 32'h0, 4'h0, 32'hFF22_FF44, "strb_rd");

        access(PORT_A, 32'h0003_FFFC, 32'hA5A5_0007, 4'hF, 32'h0, "b7_wr");
        access(PORT_B, 32'h0002_4000, 32'h5A5A_0001, 4'hF, 32'h0, "b1_wr");
        access(PORT_A, 32'h0003_FFFC, 32'h0, 4'h0, 32'hA5A5_0007, "b7_rd");
        access(PORT_A, 32'h0002_4000, 32'h0, 4'h0, 32'h5A5A_0001, "b1_rd");
        chk("err_before_oor", 32'(err), 32'h0);

        access(PORT_B, 32'h0004_0000, 32'h0, 4'h0, 32'h0, "oor_rd_lat");
        chk("err_after_oor", 32'(err), 32'h1);
        access(PORT_B, 32'h0001_FFFC, 32'hBAD0_BAD0, 4'hF, 32'h0, "oor_wr_lat");
        access(PORT_A, 32'h0002_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, "post_oor_rd");
        chk("err_sticky", 32'(err), 32'h1);

        // Reset during ISSUE of a read aborts it; memory survives.
        access(PORT_A, 32'h0002_0100, 32'hCAFE_F00D, 4'hF, 32'h0, "rst_prep_wr");
        @(posedge clk);
        #1;
        drive(PORT_A, 1'b1, 32'h0002_0100, 32'h0, 4'h0);
        expect_resp(PORT_A, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        q.delete();
        drive(PORT_A, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk_quiet("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        access(PORT_A, 32'h0002_0100, 32'h0, 4'h0, 32'hCAFE_F00D, "rst_rd_lat");
        chk("err_after_rst", 32'(err), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
